// File: rtl/mig_burst_tester_pkg.sv
// Shared types for the MIG burst tester: FSM state encoding and app_cmd opcodes.
package mig_tb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CAL,
      WRITE,
      W2R,
      READ,
      DONE
   } state_t;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mig_pattern_gen.sv
// Combinational test-pattern generator: 32-bit lane (seed + index, optionally
// inverted) replicated across the full app data width.
module mig_pattern_gen #(
   parameter int APP_DATA_W = 256,
   parameter int CNT_W      = 10
) (
   input  logic [31:0]           seed,
   input  logic                  inv,
   input  logic [CNT_W-1:0]      index,
   output logic [APP_DATA_W-1:0] word
);

   logic [31:0] sum;
   logic [31:0] lane;

   assign sum  = seed + 32'(index);
   assign lane = inv ? ~sum : sum;

   generate
      for (genvar gi = 0; gi < APP_DATA_W / 32; gi++) begin : g_lane
         assign word[gi*32 +: 32] = lane;
      end
   endgenerate

endmodule

// File: rtl/mig_burst_tester.sv
// Write-then-readback traffic engine on the MIG 7-series app interface.
// Writes num_words pattern words from base_addr, reads them back and counts
// mismatching beats. Command and write-data paths advance independently but
// are kept within one word of each other.
module mig_burst_tester
   import mig_tb_pkg::*;
#(
   parameter int APP_ADDR_W = 29,
   parameter int APP_DATA_W = 256,
   parameter int ADDR_STEP  = 8,
   parameter int CNT_W      = 10,
   parameter int ERR_W      = 16
) (
   input  logic                    ui_clk,
   input  logic                    sys_rst,
   input  logic                    init_calib_complete,
   input  logic                    start,
   input  logic [APP_ADDR_W-1:0]   base_addr,
   input  logic [CNT_W-1:0]        num_words,
   input  logic [31:0]             pat_seed,
   input  logic                    pat_inv,
   output logic [APP_ADDR_W-1:0]   app_addr,
   output logic [2:0]              app_cmd,
   output logic                    app_en,
   input  logic                    app_rdy,
   output logic [APP_DATA_W-1:0]   app_wdf_data,
   output logic                    app_wdf_wren,
   output logic                    app_wdf_end,
   output logic [APP_DATA_W/8-1:0] app_wdf_mask,
   input  logic                    app_wdf_rdy,
   input  logic [APP_DATA_W-1:0]   app_rd_data,
   input  logic                    app_rd_data_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    aborted,
   output logic [ERR_W-1:0]        err_cnt,
   output logic [APP_ADDR_W-1:0]   first_err_addr
);

   state_t                  state_reg, state_next;
   logic [APP_ADDR_W-1:0]   base_reg, base_next;
   logic [CNT_W-1:0]        num_reg, num_next;
   logic [31:0]             seed_reg, seed_next;
   logic                    inv_reg, inv_next;
   logic [CNT_W-1:0]        wcmd_reg, wcmd_next;
   logic [CNT_W-1:0]        wdat_reg, wdat_next;
   logic [CNT_W-1:0]        rcmd_reg, rcmd_next;
   logic [CNT_W-1:0]        rbeat_reg, rbeat_next;
   logic [APP_ADDR_W-1:0]   app_addr_reg, app_addr_next;
   logic [2:0]              app_cmd_reg, app_cmd_next;
   logic                    app_en_reg, app_en_next;
   logic [APP_DATA_W-1:0]   app_wdf_data_reg, app_wdf_data_next;
   logic                    app_wdf_wren_reg, app_wdf_wren_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;
   logic                    aborted_reg, aborted_next;
   logic [ERR_W-1:0]        err_cnt_reg, err_cnt_next;
   logic [APP_ADDR_W-1:0]   first_err_reg, first_err_next;
   logic [APP_DATA_W-1:0]   wr_word;
   logic [APP_DATA_W-1:0]   cmp_word;

   // Address of word idx; wraps naturally at the app_addr width.
   function automatic logic [APP_ADDR_W-1:0] word_addr(input logic [APP_ADDR_W-1:0] base,
                                                       input logic [CNT_W-1:0]      idx);
      return base + APP_ADDR_W'(idx) * APP_ADDR_W'(ADDR_STEP);
   endfunction

   // Write data follows the accepted-data counter so it stays stable while stalled.
   mig_pattern_gen #(.APP_DATA_W(APP_DATA_W), .CNT_W(CNT_W)) u_wr_gen (
      .seed  (seed_reg),
      .inv   (inv_reg),
      .index (wdat_next),
      .word  (wr_word)
   );

   // Expected read data for the next in-order beat.
   mig_pattern_gen #(.APP_DATA_W(APP_DATA_W), .CNT_W(CNT_W)) u_cmp_gen (
      .seed  (seed_reg),
      .inv   (inv_reg),
      .index (rbeat_reg),
      .word  (cmp_word)
   );

   // FSM next state, counters, latched job parameters and status.
   always_comb begin
      state_next     = state_reg;
      base_next      = base_reg;
      num_next       = num_reg;
      seed_next      = seed_reg;
      inv_next       = inv_reg;
      wcmd_next      = wcmd_reg;
      wdat_next      = wdat_reg;
      rcmd_next      = rcmd_reg;
      rbeat_next     = rbeat_reg;
      busy_next      = busy_reg;
      done_next      = done_reg;
      aborted_next   = aborted_reg;
      err_cnt_next   = err_cnt_reg;
      first_err_next = first_err_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               base_next      = base_addr;
               num_next       = num_words;
               seed_next      = pat_seed;
               inv_next       = pat_inv;
               wcmd_next      = '0;
               wdat_next      = '0;
               rcmd_next      = '0;
               rbeat_next     = '0;
               err_cnt_next   = '0;
               first_err_next = '0;
               done_next      = 1'b0;
               aborted_next   = 1'b0;
               busy_next      = 1'b1;
               state_next     = WAIT_CAL;
            end
         end
         WAIT_CAL: begin
            if (init_calib_complete) begin
               state_next = (num_reg == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            if (!init_calib_complete) begin
               aborted_next = 1'b1;
               state_next   = DONE;
            end else begin
               if (app_en_reg && app_rdy) begin
                  wcmd_next = wcmd_reg + CNT_W'(1);
               end
               if (app_wdf_wren_reg && app_wdf_rdy) begin
                  wdat_next = wdat_reg + CNT_W'(1);
               end
               if (wcmd_next == num_reg && wdat_next == num_reg) begin
                  state_next = W2R;
               end
            end
         end
         W2R: begin
            if (!init_calib_complete) begin
               aborted_next = 1'b1;
               state_next   = DONE;
            end else begin
               state_next = READ;
            end
         end
         READ: begin
            if (!init_calib_complete) begin
               aborted_next = 1'b1;
               state_next   = DONE;
            end else begin
               if (app_en_reg && app_rdy) begin
                  rcmd_next = rcmd_reg + CNT_W'(1);
               end
               if (app_rd_data_valid) begin
                  rbeat_next = rbeat_reg + CNT_W'(1);
                  if (app_rd_data != cmp_word) begin
                     if (err_cnt_reg == '0) begin
                        first_err_next = word_addr(base_reg, rbeat_reg);
                     end
                     if (err_cnt_reg != {ERR_W{1'b1}}) begin
                        err_cnt_next = err_cnt_reg + ERR_W'(1);
                     end
                  end
                  if (rbeat_reg == num_reg - CNT_W'(1)) begin
                     state_next = DONE;
                  end
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Completion status is published together with entry into DONE.
      if (state_next == DONE && state_reg != DONE) begin
         busy_next = 1'b0;
         done_next = 1'b1;
      end
   end

   // App-interface drive for the coming cycle, derived from the post-handshake counters.
   always_comb begin
      app_en_next       = 1'b0;
      app_wdf_wren_next = 1'b0;
      app_cmd_next      = CMD_WRITE;
      app_addr_next     = app_addr_reg;
      app_wdf_data_next = app_wdf_data_reg;

      if (state_next == WRITE) begin
         // Command may run one word ahead of data and data one word ahead of command.
         app_en_next       = (wcmd_next < num_reg) && (wcmd_next <= wdat_next);
         app_addr_next     = word_addr(base_reg, wcmd_next);
         app_wdf_wren_next = (wdat_next < num_reg) && (wdat_next <= wcmd_next);
         app_wdf_data_next = wr_word;
      end else if (state_next == READ) begin
         app_en_next   = (rcmd_next < num_reg);
         app_cmd_next  = CMD_READ;
         app_addr_next = word_addr(base_reg, rcmd_next);
      end
   end

   // State and output registers; asynchronous reset returns everything to zero.
   always_ff @(posedge ui_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_reg        <= IDLE;
         base_reg         <= '0;
         num_reg          <= '0;
         seed_reg         <= '0;
         inv_reg          <= 1'b0;
         wcmd_reg         <= '0;
         wdat_reg         <= '0;
         rcmd_reg         <= '0;
         rbeat_reg        <= '0;
         app_addr_reg     <= '0;
         app_cmd_reg      <= CMD_WRITE;
         app_en_reg       <= 1'b0;
         app_wdf_data_reg <= '0;
         app_wdf_wren_reg <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         aborted_reg      <= 1'b0;
         err_cnt_reg      <= '0;
         first_err_reg    <= '0;
      end else begin
         state_reg        <= state_next;
         base_reg         <= base_next;
         num_reg          <= num_next;
         seed_reg         <= seed_next;
         inv_reg          <= inv_next;
         wcmd_reg         <= wcmd_next;
         wdat_reg         <= wdat_next;
         rcmd_reg         <= rcmd_next;
         rbeat_reg        <= rbeat_next;
         app_addr_reg     <= app_addr_next;
         app_cmd_reg      <= app_cmd_next;
         app_en_reg       <= app_en_next;
         app_wdf_data_reg <= app_wdf_data_next;
         app_wdf_wren_reg <= app_wdf_wren_next;
         busy_reg         <= busy_next;
         done_reg         <= done_next;
         aborted_reg      <= aborted_next;
         err_cnt_reg      <= err_cnt_next;
         first_err_reg    <= first_err_next;
      end
   end

   assign app_addr       = app_addr_reg;
   assign app_cmd        = app_cmd_reg;
   assign app_en         = app_en_reg;
   assign app_wdf_data   = app_wdf_data_reg;
   assign app_wdf_wren   = app_wdf_wren_reg;
   assign app_wdf_end    = app_wdf_wren_reg;
   assign app_wdf_mask   = '0;
   assign busy           = busy_reg;
   assign done           = done_reg;
   assign aborted        = aborted_reg;
   assign err_cnt        = err_cnt_reg;
   assign first_err_addr = first_err_reg;

endmodule

// File: tb/tb_mig_burst_tester.sv
// Bench for mig_burst_tester: MIG app-interface model with random stalls and a
// fixed 20-cycle read latency, checked against an arithmetic reference model.
module tb_mig_burst_tester;
   import mig_tb_pkg::*;

   localparam int AW = 29;
   localparam int DW = 256;
   localparam int STEP = 8;
   localparam int LAT = 20;

   logic            ui_clk = 1'b0;
   logic            sys_rst = 1'b0;
   logic            init_calib_complete = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [9:0]      num_words = '0;
   logic [31:0]     pat_seed = '0;
   logic            pat_inv = 1'b0;
   logic [AW-1:0]   app_addr;
   logic [2:0]      app_cmd;
   logic            app_en;
   logic            app_rdy = 1'b0;
   logic [DW-1:0]   app_wdf_data;
   logic            app_wdf_wren;
   logic            app_wdf_end;
   logic [DW/8-1:0] app_wdf_mask;
   logic            app_wdf_rdy = 1'b0;
   logic [DW-1:0]   app_rd_data = '0;
   logic            app_rd_data_valid = 1'b0;
   logic            busy, done, aborted;
   logic [15:0]     err_cnt;
   logic [AW-1:0]   first_err_addr;

   int vectors = 0;
   int miscompares = 0;

   // MIG model state
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [AW-1:0] wcmd_log[$];
   logic [DW-1:0] wdat_log[$];
   logic [AW-1:0] rcmd_log[$];
   logic [AW-1:0] rd_q[$];
   int            rd_due[$];
   int            mem_ptr = 0;
   int            beat_n = 0;
   int            cyc = 0;
   int            act_cycles = 0;
   int            rdy_pct = 100;
   int            corrupt_idx = -1;
   bit            chk_stable = 1'b0;
   logic          prev_en = 1'b0, prev_rdy = 1'b0, prev_wren = 1'b0, prev_wrdy = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [2:0]    prev_cmd = '0;
   logic [DW-1:0] prev_data = '0;

   mig_burst_tester dut (
      .ui_clk              (ui_clk),
      .sys_rst             (sys_rst),
      .init_calib_complete (init_calib_complete),
      .start               (start),
      .base_addr           (base_addr),
      .num_words           (num_words),
      .pat_seed            (pat_seed),
      .pat_inv             (pat_inv),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .busy                (busy),
      .done                (done),
      .aborted             (aborted),
      .err_cnt             (err_cnt),
      .first_err_addr      (first_err_addr)
   );

   always #5 ui_clk = ~ui_clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_word(input logic [31:0] seed, input logic inv, input int i);
      logic [31:0] v;
      v = seed + 32'(i);
      if (inv) v = ~v;
      return {8{v}};
   endfunction

   function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] base, input int i);
      return base + AW'(i * STEP);
   endfunction

   // MIG app model: decides ready at the falling edge, so a handshake seen here
   // is exactly what the DUT samples on the next rising edge.
   always @(negedge ui_clk) begin
      cyc++;
      if (!sys_rst) begin
         app_rdy = 1'b0;
         app_wdf_rdy = 1'b0;
         app_rd_data_valid = 1'b0;
         prev_en = 1'b0;
         prev_wren = 1'b0;
      end else begin
         if (chk_stable) begin
            if (prev_en && !prev_rdy) begin
               chk("hold_en", app_en, 1);
               chk("hold_addr", app_addr, prev_addr);
               chk("hold_cmd", app_cmd, prev_cmd);
            end
            if (prev_wren && !prev_wrdy) begin
               chk("hold_wren", app_wdf_wren, 1);
               chk("hold_data", app_wdf_data, prev_data);
            end
            if (app_wdf_wren) chk("wdf_end", app_wdf_end, 1);
         end
         if (app_en || app_wdf_wren) act_cycles++;
         app_rdy = ($urandom_range(99) < rdy_pct);
         app_wdf_rdy = ($urandom_range(99) < rdy_pct);
         if (app_en && app_rdy) begin
            if (app_cmd == CMD_WRITE) begin
               wcmd_log.push_back(app_addr);
            end else begin
               rcmd_log.push_back(app_addr);
               rd_q.push_back(app_addr);
               rd_due.push_back(cyc + LAT);
            end
         end
         if (app_wdf_wren && app_wdf_rdy) wdat_log.push_back(app_wdf_data);
         while (mem_ptr < wcmd_log.size() && mem_ptr < wdat_log.size()) begin
            mem[wcmd_log[mem_ptr]] = wdat_log[mem_ptr];
            mem_ptr++;
         end
         app_rd_data_valid = 1'b0;
         if (rd_q.size() > 0 && rd_due[0] <= cyc) begin
            app_rd_data = mem.exists(rd_q[0]) ? mem[rd_q[0]] : '0;
            if (beat_n == corrupt_idx) app_rd_data[0] = ~app_rd_data[0];
            app_rd_data_valid = 1'b1;
            beat_n++;
            void'(rd_q.pop_front());
            void'(rd_due.pop_front());
         end
         prev_en = app_en;
         prev_rdy = app_rdy;
         prev_addr = app_addr;
         prev_cmd = app_cmd;
         prev_wren = app_wdf_wren;
         prev_wrdy = app_wdf_rdy;
         prev_data = app_wdf_data;
      end
   end

   task automatic launch(input logic [AW-1:0] base, input int num, input logic [31:0] seed,
                         input logic inv, input int pct, input int cidx, input bit stable);
      @(negedge ui_clk);
      #2;
      wcmd_log.delete(); wdat_log.delete(); rcmd_log.delete();
      rd_q.delete(); rd_due.delete(); mem.delete();
      mem_ptr = 0; beat_n = 0; act_cycles = 0;
      corrupt_idx = cidx; rdy_pct = pct; chk_stable = stable;
      base_addr = base; num_words = 10'(num); pat_seed = seed; pat_inv = inv;
      start = 1'b1;
      @(negedge ui_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000; i++) begin
         if (done) break;
         @(negedge ui_clk);
      end
      chk({tag, "_done"}, done, 1);
      chk({tag, "_busy"}, busy, 0);
   endtask

   task automatic check_run(input string tag, input logic [AW-1:0] base, input int num,
                            input logic [31:0] seed, input logic inv, input int cidx);
      int exp_err;
      chk({tag, "_aborted"}, aborted, 0);
      chk({tag, "_nwcmd"}, wcmd_log.size(), num);
      chk({tag, "_nwdat"}, wdat_log.size(), num);
      chk({tag, "_nrcmd"}, rcmd_log.size(), num);
      for (int i = 0; i < num; i++) begin
         if (i < wcmd_log.size()) chk($sformatf("%s_waddr%0d", tag, i), wcmd_log[i], ref_addr(base, i));
         if (i < wdat_log.size()) chk($sformatf("%s_wdata%0d", tag, i), wdat_log[i], ref_word(seed, inv, i));
         if (i < rcmd_log.size()) chk($sformatf("%s_raddr%0d", tag, i), rcmd_log[i], ref_addr(base, i));
      end
      exp_err = (cidx >= 0 && cidx < num) ? 1 : 0;
      chk({tag, "_err_cnt"}, err_cnt, exp_err);
      if (exp_err != 0) chk({tag, "_first_err"}, first_err_addr, ref_addr(base, cidx));
      $display("run %s base=%0h num=%0d seed=%0h inv=%0d err=%0d", tag, base, num, seed, inv, err_cnt);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_app_en"}, app_en, 0);
      chk({tag, "_wren"}, app_wdf_wren, 0);
      chk({tag, "_cmd"}, app_cmd, 0);
      chk({tag, "_addr"}, app_addr, 0);
      chk({tag, "_wdata"}, app_wdf_data, 0);
      chk({tag, "_mask"}, app_wdf_mask, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_aborted"}, aborted, 0);
      chk({tag, "_err"}, err_cnt, 0);
      chk({tag, "_ferr"}, first_err_addr, 0);
   endtask

   initial begin
      logic [AW-1:0] rb;
      int rn, rc;
      logic [31:0] rs;
      bit timed_out;

      // Reset state
      repeat (3) @(negedge ui_clk);
      check_zero("reset");
      sys_rst = 1'b1;
      repeat (2) @(negedge ui_clk);

      // 1: plain burst, calibration arrives late
      launch(29'h0, 20, 32'h0, 1'b0, 100, -1, 1'b1);
      repeat (5) @(negedge ui_clk);
      chk("t1_wait_busy", busy, 1);
      chk("t1_wait_idle_bus", act_cycles, 0);
      init_calib_complete = 1'b1;
      wait_done("t1");
      check_run("t1", 29'h0, 20, 32'h0, 1'b0, -1);

      // 2: same job with 50% stalls on both ready lines
      launch(29'h0, 20, 32'h0, 1'b0, 50, -1, 1'b1);
      wait_done("t2");
      check_run("t2", 29'h0, 20, 32'h0, 1'b0, -1);

      // 3: corrupted read beat 5
      launch(29'h100, 8, 32'h1234_5678, 1'b0, 100, 5, 1'b1);
      wait_done("t3");
      check_run("t3", 29'h100, 8, 32'h1234_5678, 1'b0, 5);
      chk("t3_first_err_const", first_err_addr, 29'h128);

      // 4: address wrap and inverted pattern
      launch(29'h1FFF_FFF0, 4, 32'hFFFF_FFFF, 1'b1, 70, -1, 1'b1);
      wait_done("t4");
      check_run("t4", 29'h1FFF_FFF0, 4, 32'hFFFF_FFFF, 1'b1, -1);
      if (wcmd_log.size() == 4) begin
         chk("t4_wrap_addr2", wcmd_log[2], 29'h0);
         chk("t4_wrap_addr3", wcmd_log[3], 29'h8);
      end
      if (wdat_log.size() > 1) chk("t4_word1", wdat_log[1], {8{32'hFFFF_FFFF}});

      // Randomised jobs
      for (int r = 0; r < 4; r++) begin
         rb = 29'($urandom());
         rn = $urandom_range(30, 1);
         rs = $urandom();
         rc = $urandom_range(rn + 4);
         launch(rb, rn, rs, 1'($urandom_range(1)), $urandom_range(100, 30), rc, 1'b1);
         wait_done($sformatf("rnd%0d", r));
         check_run($sformatf("rnd%0d", r), rb, rn, rs, pat_inv, rc);
      end

      // 5: calibration lost in the middle of WRITE
      launch(29'h40, 200, 32'h55, 1'b0, 100, -1, 1'b0);
      timed_out = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge ui_clk);
         if (wcmd_log.size() >= 5) begin
            timed_out = 1'b0;
            break;
         end
      end
      chk("t5_reach_write", timed_out, 0);
      init_calib_complete = 1'b0;
      @(negedge ui_clk);
      chk("t5_app_en", app_en, 0);
      chk("t5_wren", app_wdf_wren, 0);
      chk("t5_aborted", aborted, 1);
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      chk("t5_partial", (wcmd_log.size() < 200), 1);
      $display("run t5 abort after %0d write cmds", wcmd_log.size());
      init_calib_complete = 1'b1;

      // 6a: zero-length job
      launch(29'h10, 0, 32'h0, 1'b0, 100, -1, 1'b1);
      wait_done("t6a");
      chk("t6a_no_traffic", act_cycles, 0);
      chk("t6a_aborted", aborted, 0);
      chk("t6a_err", err_cnt, 0);
      $display("run t6a num=0 traffic_cycles=%0d", act_cycles);

      // 6b: asynchronous reset during READ
      launch(29'h200, 50, 32'h9, 1'b0, 100, -1, 1'b0);
      timed_out = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge ui_clk);
         if (rcmd_log.size() >= 3) begin
            timed_out = 1'b0;
            break;
         end
      end
      chk("t6b_reach_read", timed_out, 0);
      #2 sys_rst = 1'b0;
      #1;
      check_zero("t6b_async");
      $display("run t6b reset mid-read after %0d read cmds", rcmd_log.size());
      repeat (3) @(negedge ui_clk);
      sys_rst = 1'b1;

      // Recovery after reset
      launch(29'h300, 3, 32'hA5A5_0000, 1'b1, 100, -1, 1'b1);
      wait_done("post");
      check_run("post", 29'h300, 3, 32'hA5A5_0000, 1'b1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
